// File: rtl/matmul_arb_pkg.sv
// rtl/matmul_arb_pkg.sv - shared types and constants for the matmul engine arbiter.
package matmul_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      RUN   = 2'd2,
      CMPL  = 2'd3
   } state_t;

   localparam int DEFAULT_TIMEOUT = 1024;

   function automatic int wrap_inc(input int idx, input int n);
      return (idx + 1 >= n) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin pick of the first active request at or above ptr, wrapping.
module rr_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int IDX_W   = 2
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   ptr,
   output logic [NUM_REQ-1:0] winner,
   output logic [IDX_W-1:0]   winner_idx
);

   logic found;
   int   idx;

   always_comb begin
      found      = 1'b0;
      winner_idx = '0;
      idx        = 0;
      for (int i = 0; i < NUM_REQ; i++) begin
         idx = int'(ptr) + i;
         if (idx >= NUM_REQ) begin
            idx = idx - NUM_REQ;
         end
         if (!found && req[idx[IDX_W-1:0]]) begin
            found      = 1'b1;
            winner_idx = idx[IDX_W-1:0];
         end
      end
      winner = NUM_REQ'(found) << winner_idx;
   end

endmodule

// File: rtl/matmul_arb.sv
// rtl/matmul_arb.sv - shares one matmul engine among NUM_REQ requesters with address relocation.
// Optional MATMUL_ARB_TIMEOUT_EN adds a RUN watchdog (TIMEOUT parameter, err output).
module matmul_arb
   import matmul_arb_pkg::*;
#(
   parameter int NUM_REQ    = 4,
   parameter int ADDR_WIDTH = 6,
   parameter int BASE_WIDTH = 10
`ifdef MATMUL_ARB_TIMEOUT_EN
   ,
   parameter int TIMEOUT    = DEFAULT_TIMEOUT
`endif
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic [NUM_REQ-1:0]            req,
   input  logic [NUM_REQ*BASE_WIDTH-1:0] x_base,
   input  logic [NUM_REQ*BASE_WIDTH-1:0] y_base,
   input  logic [NUM_REQ*BASE_WIDTH-1:0] z_base,
   output logic [NUM_REQ-1:0]            grant,
   output logic [NUM_REQ-1:0]            cmp,
   output logic                          eng_start,
   input  logic                          eng_done,
   input  logic [ADDR_WIDTH-1:0]         eng_x_addr,
   input  logic [ADDR_WIDTH-1:0]         eng_y_addr,
   input  logic [ADDR_WIDTH-1:0]         eng_z_addr,
   input  logic                          eng_z_wr_en,
   output logic [BASE_WIDTH-1:0]         mem_x_addr,
   output logic [BASE_WIDTH-1:0]         mem_y_addr,
   output logic [BASE_WIDTH-1:0]         mem_z_addr,
   output logic                          mem_z_wr_en
`ifdef MATMUL_ARB_TIMEOUT_EN
   ,
   output logic                          err
`endif
);

   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   state_t                 state;
   state_t                 state_nxt;
   logic [IDX_W-1:0]       ptr;
   logic [IDX_W-1:0]       win_idx;
   logic [NUM_REQ-1:0]     win_onehot;
   logic [NUM_REQ-1:0]     arb_onehot;
   logic [IDX_W-1:0]       arb_idx;
   logic [BASE_WIDTH-1:0]  x_lat, y_lat, z_lat;
   logic [BASE_WIDTH-1:0]  x_sel, y_sel, z_sel;
   logic                   done_prev;
   logic                   done_rise;
   logic                   timeout;
   logic                   addr_valid;

   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_rr_arbiter (
      .req        (req),
      .ptr        (ptr),
      .winner     (arb_onehot),
      .winner_idx (arb_idx)
   );

   // Only a fresh 0->1 transition ends a job, so a stale done level is ignored.
   assign done_rise = eng_done & ~done_prev;

`ifdef MATMUL_ARB_TIMEOUT_EN
   localparam int TMR_W = $clog2(TIMEOUT + 1);

   logic [TMR_W-1:0] tmr;
   logic             tmo_flag;

   assign timeout = (state == RUN) && (tmr == TMR_W'(TIMEOUT - 1)) && !done_rise;
   assign err     = (state == CMPL) && tmo_flag;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         tmr      <= '0;
         tmo_flag <= 1'b0;
      end else begin
         if (state == RUN) begin
            tmr <= tmr + 1'b1;
         end else begin
            tmr <= '0;
         end
         if (timeout) begin
            tmo_flag <= 1'b1;
         end else if (state == IDLE) begin
            tmo_flag <= 1'b0;
         end
      end
   end
`else
   assign timeout = 1'b0;
`endif

   always_comb begin
      x_sel = '0;
      y_sel = '0;
      z_sel = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (arb_idx == IDX_W'(i)) begin
            x_sel = x_base[i*BASE_WIDTH +: BASE_WIDTH];
            y_sel = y_base[i*BASE_WIDTH +: BASE_WIDTH];
            z_sel = z_base[i*BASE_WIDTH +: BASE_WIDTH];
         end
      end
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (|req) state_nxt = START;
         START:   state_nxt = RUN;
         RUN:     if (done_rise || timeout) state_nxt = CMPL;
         CMPL:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         ptr       <= '0;
         win_idx   <= '0;
         x_lat     <= '0;
         y_lat     <= '0;
         z_lat     <= '0;
         done_prev <= 1'b0;
      end else begin
         state     <= state_nxt;
         done_prev <= eng_done;
         if (state == IDLE && |req) begin
            win_idx <= arb_idx;
            x_lat   <= x_sel;
            y_lat   <= y_sel;
            z_lat   <= z_sel;
         end
         if (state == CMPL) begin
            ptr <= IDX_W'(wrap_inc(int'(win_idx), NUM_REQ));
         end
      end
   end

   assign win_onehot  = NUM_REQ'(1) << win_idx;
   assign grant       = (state != IDLE) ? win_onehot : '0;
   assign cmp         = (state == CMPL) ? win_onehot : '0;
   assign eng_start   = (state == START);
   assign addr_valid  = (state == START) || (state == RUN);
   assign mem_z_wr_en = (state == RUN) && eng_z_wr_en;

   assign mem_x_addr = addr_valid ? x_lat + BASE_WIDTH'(eng_x_addr) : '0;
   assign mem_y_addr = addr_valid ? y_lat + BASE_WIDTH'(eng_y_addr) : '0;
   assign mem_z_addr = addr_valid ? z_lat + BASE_WIDTH'(eng_z_addr) : '0;

endmodule

// File: tb/tb_matmul_arb.sv
// tb/tb_matmul_arb.sv - directed self-checking bench for matmul_arb (default build).
module tb_matmul_arb;

   logic        clock = 1'b0;
   logic        reset;
   logic [3:0]  req;
   logic [39:0] x_base, y_base, z_base;
   logic [3:0]  grant, cmp;
   logic        eng_start, eng_done;
   logic [5:0]  eng_x_addr, eng_y_addr, eng_z_addr;
   logic        eng_z_wr_en;
   logic [9:0]  mem_x_addr, mem_y_addr, mem_z_addr;
   logic        mem_z_wr_en;
`ifdef MATMUL_ARB_TIMEOUT_EN
   logic        err;
`endif

   int total = 0;
   int bad   = 0;

   always #5 clock = ~clock;

   matmul_arb #(
      .NUM_REQ    (4),
      .ADDR_WIDTH (6),
      .BASE_WIDTH (10)
   ) dut (
      .clock       (clock),
      .reset       (reset),
      .req         (req),
      .x_base      (x_base),
      .y_base      (y_base),
      .z_base      (z_base),
      .grant       (grant),
      .cmp         (cmp),
      .eng_start   (eng_start),
      .eng_done    (eng_done),
      .eng_x_addr  (eng_x_addr),
      .eng_y_addr  (eng_y_addr),
      .eng_z_addr  (eng_z_addr),
      .eng_z_wr_en (eng_z_wr_en),
      .mem_x_addr  (mem_x_addr),
      .mem_y_addr  (mem_y_addr),
      .mem_z_addr  (mem_z_addr),
      .mem_z_wr_en (mem_z_wr_en)
`ifdef MATMUL_ARB_TIMEOUT_EN
      ,
      .err         (err)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      repeat (2) @(posedge clock);
      #1;
      reset = 1'b0;
   endtask

   task automatic set_base(input int i, input logic [9:0] x, input logic [9:0] y, input logic [9:0] z);
      x_base[i*10 +: 10] = x;
      y_base[i*10 +: 10] = y;
      z_base[i*10 +: 10] = z;
   endtask

   // One job from IDLE: bounded wait for start, then done after run_cyc RUN cycles.
   task automatic do_job(input logic [3:0] exp_g, input logic [3:0] req_after, input int run_cyc);
      int k;
      k = 0;
      while (!eng_start && k < 8) begin
         tick();
         k++;
      end
      chk("start_latency", k, 1);
      chk("start_grant", grant, exp_g);
      req = req_after;
      tick();
      chk("start_one_cycle", eng_start, 0);
      repeat (run_cyc) tick();
      chk("no_early_cmp", cmp, 0);
      eng_done = 1'b1;
      tick();
      chk("cmp_pulse", cmp, exp_g);
      eng_done = 1'b0;
      tick();
      chk("cmp_cleared", cmp, 0);
      chk("grant_cleared", grant, 0);
      chk("idle_gap_no_start", eng_start, 0);
   endtask

   initial begin
      reset       = 1'b1;
      req         = '0;
      x_base      = '0;
      y_base      = '0;
      z_base      = '0;
      eng_done    = 1'b0;
      eng_x_addr  = '0;
      eng_y_addr  = '0;
      eng_z_addr  = '0;
      eng_z_wr_en = 1'b0;
      do_reset();

      chk("rst_grant", grant, 0);
      chk("rst_cmp", cmp, 0);
      chk("rst_start", eng_start, 0);
      chk("rst_wr_en", mem_z_wr_en, 0);
      chk("rst_mem_x", mem_x_addr, 0);

      // single job from requester 1 with relocation checks
      set_base(0, 10'd1020, 10'd4, 10'd8);
      set_base(1, 10'd100, 10'd200, 10'd300);
      set_base(2, 10'd400, 10'd500, 10'd600);
      set_base(3, 10'd700, 10'd800, 10'd900);
      eng_x_addr  = 6'd7;
      eng_y_addr  = 6'd63;
      eng_z_addr  = 6'd5;
      eng_z_wr_en = 1'b1;
      chk("idle_wr_en_gated", mem_z_wr_en, 0);
      req = 4'b0010;
      tick();
      chk("j1_start", eng_start, 1);
      chk("j1_grant", grant, 4'b0010);
      chk("j1_start_wr_en", mem_z_wr_en, 0);
      chk("j1_start_mem_z", mem_z_addr, 305);
      req = 4'b0000;
      tick();
      chk("j1_run_start", eng_start, 0);
      chk("j1_run_wr_en", mem_z_wr_en, 1);
      chk("j1_run_mem_x", mem_x_addr, 107);
      chk("j1_run_mem_y", mem_y_addr, 263);
      repeat (19) tick();
      chk("j1_run_no_cmp", cmp, 0);
      chk("j1_run_grant", grant, 4'b0010);
      eng_done = 1'b1;
      tick();
      chk("j1_cmp", cmp, 4'b0010);
      chk("j1_cmpl_wr_en", mem_z_wr_en, 0);
      chk("j1_cmpl_mem_x", mem_x_addr, 0);
      eng_done = 1'b0;
      tick();
      chk("j1_idle_cmp", cmp, 0);
      chk("j1_idle_grant", grant, 0);
      chk("j1_idle_mem_z", mem_z_addr, 0);
      eng_z_wr_en = 1'b0;

      // all requesting: rotation 0,1,2,3,0 from a fresh pointer
      do_reset();
      req = 4'b1111;
      do_job(4'b0001, 4'b1111, 3);
      do_job(4'b0010, 4'b1111, 0);
      do_job(4'b0100, 4'b1111, 2);
      do_job(4'b1000, 4'b1111, 1);
      do_job(4'b0001, 4'b0000, 2);

      // requester 0 arrives during requester 2's job; 3 is idle, so 0 wins
      do_reset();
      req = 4'b0100;
      do_job(4'b0100, 4'b0001, 5);
      do_job(4'b0001, 4'b0000, 1);

      // stale done level at START, plus address wrap on requester 0
      eng_done   = 1'b1;
      eng_x_addr = 6'd10;
      eng_y_addr = 6'd2;
      req        = 4'b0001;
      tick();
      chk("stale_grant", grant, 4'b0001);
      req = 4'b0000;
      tick();
      chk("wrap_mem_x", mem_x_addr, 6);
      chk("wrap_mem_y", mem_y_addr, 6);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("stale_no_cmp", cmp, 0);
      end
      eng_done = 1'b0;
      tick();
      chk("stale_low_no_cmp", cmp, 0);
      eng_done = 1'b1;
      tick();
      chk("stale_rise_cmp", cmp, 4'b0001);
      eng_done = 1'b0;
      tick();

      // reset in RUN drops the job and sends the pointer back to 0
      req = 4'b1000;
      tick();
      chk("rr_ptr1_grant", grant, 4'b1000);
      req = 4'b0000;
      tick();
      tick();
      reset = 1'b1;
      #1;
      chk("rst_run_grant", grant, 0);
      @(posedge clock);
      #1;
      reset = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("rst_run_no_cmp", cmp, 0);
      end
      req = 4'b1001;
      tick();
      chk("rst_ptr_zero_grant", grant, 4'b0001);
      req = 4'b0000;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got=timeout expected=finish");
      $fatal(1);
   end

endmodule

// File: doc/matmul_arb.md
MATMUL_ARB -- requirements
Module: matmul_arb

Interface
REQ-001 Parameter NUM_REQ, default 4, number of requesters sharing one matmul engine (2..8).
REQ-002 Parameter ADDR_WIDTH, default 6, engine-local matrix address width.
REQ-003 Parameter BASE_WIDTH, default 10, shared-memory address width.
REQ-004 clock  input  1  clock; all state changes on the rising edge.
REQ-005 reset  input  1  reset, asynchronous, active-high.
REQ-006 req  input  NUM_REQ  per-requester job request, level.
REQ-007 x_base, y_base, z_base  input  NUM_REQ*BASE_WIDTH each  per-requester matrix base addresses, packed, requester 0 in the LSBs.
REQ-008 grant  output  NUM_REQ  one-hot owner of the engine; all zero when no job runs.
REQ-009 cmp  output  NUM_REQ  one-cycle completion pulse to the owner.
REQ-010 eng_start  output  1  start pulse to the engine.
REQ-011 eng_done  input  1  engine done flag, level.
REQ-012 eng_x_addr, eng_y_addr, eng_z_addr  input  ADDR_WIDTH each  engine-local addresses.
REQ-013 eng_z_wr_en  input  1  engine write strobe.
REQ-014 mem_x_addr, mem_y_addr, mem_z_addr  output  BASE_WIDTH each  relocated shared-memory addresses.
REQ-015 mem_z_wr_en  output  1  gated write strobe to shared memory.

Function
REQ-016 FSM states SHALL be IDLE, START, RUN, CMPL.
REQ-017 IDLE: if any req bit is set, the block SHALL select a winner round-robin from index ptr upward (wrapping), latch winner index and its three bases, and go to START; otherwise it SHALL stay in IDLE.
REQ-018 START: eng_start=1 for exactly one cycle; grant[winner]=1; next state RUN.
REQ-019 RUN: grant[winner] held; the block SHALL leave RUN only on a rising edge of eng_done (current 1, registered previous 0), going to CMPL; a done level left high from an earlier job SHALL be ignored.
REQ-020 CMPL: cmp[winner]=1 for one cycle; ptr becomes winner+1 modulo NUM_REQ; grant cleared at the next edge; next state IDLE.
REQ-021 Minimum turnaround: a req seen in IDLE yields eng_start at the next cycle; back-to-back jobs incur one IDLE cycle between cmp and the next eng_start.
REQ-022 Deasserting req during START/RUN SHALL NOT abort the job; cmp is still issued.
REQ-023 Requests arriving during a job SHALL wait; no request is lost while held.
REQ-024 mem_*_addr SHALL equal latched base + zero-extended eng_*_addr, truncated to BASE_WIDTH (wrap modulo 2^BASE_WIDTH), combinationally.
REQ-025 mem_z_wr_en SHALL equal eng_z_wr_en only in RUN; 0 in all other states.
REQ-026 Outside START/RUN, mem_*_addr SHALL be 0.

Reset
REQ-027 On reset, state=IDLE, ptr=0, latched bases=0, grant=0, cmp=0, eng_start=0, mem_z_wr_en=0, done history=0.
REQ-028 Reset mid-job SHALL abandon the job with no cmp; arbitration restarts from requester 0.

Configuration
REQ-029 Macro MATMUL_ARB_TIMEOUT_EN defined: add parameter TIMEOUT (default 1024) and output err (1 bit); if RUN lasts TIMEOUT cycles without eng_done rising, go to CMPL, pulse err with cmp; err reset value 0.
REQ-030 Macro undefined: no err port and no counter; RUN waits indefinitely.

Structure
REQ-031 Package matmul_arb_pkg SHALL hold state_t (2-bit enum) and the default TIMEOUT constant.
REQ-032 Round-robin selection SHALL be sub-module rr_arbiter (inputs req, ptr; outputs one-hot winner and its index).

Verification
REQ-033 req=4'b0010, bases x=100,y=200,z=300; engine done after 20 cycles -> eng_start 1 cycle after req, grant=0010, cmp[1] pulses once, mem_z_addr=300+eng_z_addr.
REQ-034 req=4'b1111 held -> grant order 0,1,2,3,0; each cmp before next eng_start.
REQ-035 req=4'b0001 during job of requester 2 (ptr=3) -> requester 3 not requesting, requester 0 granted next.
REQ-036 eng_done already 1 at START -> no CMPL until done falls and rises again.
REQ-037 x_base=1020, eng_x_addr=10, BASE_WIDTH=10 -> mem_x_addr=6.
REQ-038 reset asserted in RUN -> grant=0, cmp never pulses; with MATMUL_ARB_TIMEOUT_EN, TIMEOUT=16 and no done -> cmp and err pulse on cycle 16 of RUN.
